bcd_updown_counter_n: RTL and testbench
=======================================

// Module: bcd_updown_counter_n
// PURPOSE
// - Parametrised N-digit BCD up/down counter with programmable range, preset load and wrap/saturate mode.
// - Successor of the single-digit 0..9 setting counter used by the clock/alarm time-set path.
// - Sits between the debounced push-button decoder (up/down/Ld) and the display and time registers.
// - Adds carry/borrow outputs for cascading fields (seconds -> minutes -> hours).
// PARAMETERS
// - DIGITS      2    number of BCD digits; out is 4*DIGITS bits wide
// - MIN_VAL     0    lowest count value (decimal)
// - MAX_VAL     59   highest count value (decimal); must be < 10**DIGITS
// - LOAD_VAL    6    value loaded by Ld (decimal); MIN_VAL <= LOAD_VAL <= MAX_VAL
// - REP_DELAY   8    auto-repeat: EN ticks a button is held before repeating starts (CNT_AUTOREPEAT_EN only)
// - REP_PERIOD  2    auto-repeat: EN ticks between repeated steps (CNT_AUTOREPEAT_EN only)
// PORTS
// - clk     in   1           system clock; all state updates on posedge
// - rst     in   1           synchronous, active-high reset
// - EN      in   1           count enable / tick; no state change except reset when low
// - up      in   1           increment request
// - down    in   1           decrement request
// - Ld      in   1           load LOAD_VAL
// - wrap    in   1           1 = wrap at limits, 0 = saturate at limits
// - out     out  4*DIGITS    BCD count value, digit 0 in [3:0]
// - carry   out  1           one-cycle pulse on an up-wrap MAX_VAL -> MIN_VAL
// - borrow  out  1           one-cycle pulse on a down-wrap MIN_VAL -> MAX_VAL
// - at_max  out  1           high while out == MAX_VAL
// - at_min  out  1           high while out == MIN_VAL
// BEHAVIOUR
// - Reset: out = MIN_VAL (BCD), carry = 0, borrow = 0, at_min = 1, at_max = (MIN_VAL == MAX_VAL); auto-repeat state cleared.
// - All outputs are registered. A step or load is visible on out one clk after the sampling edge.
// - Priority, evaluated every posedge: rst > !EN (hold) > Ld > step.
// - Step request: `step_up = up & ~down`, `step_dn = down & ~up`. When up and down are both 1, the counter holds.
// - Step up:
//   - out < MAX_VAL: out + 1.
//   - out == MAX_VAL, wrap = 1: out = MIN_VAL and carry = 1.
//   - out == MAX_VAL, wrap = 0: hold, carry stays 0.
// - Step down:
//   - out > MIN_VAL: out - 1.
//   - out == MIN_VAL, wrap = 1: out = MAX_VAL and borrow = 1.
//   - out == MIN_VAL, wrap = 0: hold, borrow stays 0.
// - BCD arithmetic is per digit.
//   - Increment: digit 9 -> 0 with ripple to the next digit.
//   - Decrement: digit 0 -> 9 with ripple to the next digit.
//   - out must never hold a non-BCD nibble.
// - carry and borrow are high for exactly the one clk following the wrap edge, then return to 0.
// - at_max and at_min are registered together with out and are always consistent with it.
// - Ld takes priority over a simultaneous step and produces no carry or borrow. Ld is ignored while EN = 0.
// - wrap is sampled only on the step edge; changing it never alters out by itself.
// - Reset asserted at any time, including mid-repeat, forces the reset state on the next edge.
// - Parameter violations (MIN_VAL > MAX_VAL, LOAD_VAL out of range, MAX_VAL >= 10**DIGITS) are fatal in simulation via an initial check.
// CONFIGURATION
// - CNT_AUTOREPEAT_EN undefined:
//   - up/down are level-sensitive: one step on every EN tick while asserted.
//   - REP_DELAY and REP_PERIOD are unused.
// - CNT_AUTOREPEAT_EN defined:
//   - Each request is edge-qualified. One step occurs on the first EN tick after the request rises.
//   - While the request stays high, the next step occurs after REP_DELAY EN ticks, then one step every REP_PERIOD EN ticks.
//   - Releasing the request, or asserting both up and down, clears the repeat counter.
//   - Ld also clears the repeat counter.
// TESTING
// - Defaults, rst = 1 for 2 clk -> out = 8'h00, at_min = 1, carry = 0, borrow = 0.
// - EN = 1, Ld = 1 with up = 1 -> next clk out = 8'h06, carry = 0; Ld with EN = 0 -> out unchanged.
// - Load 58, up held, wrap = 1 -> out 59, then 00 with carry = 1 for one clk, at_max = 1 while at 59.
// - out = 00, down, wrap = 0 -> out stays 00, borrow = 0. With wrap = 1 -> out = 59, borrow = 1 for one clk.
// - up = down = 1 for 5 EN ticks -> out constant. Up from 09 -> 10 (digit ripple, no 0x0A nibble). Down from 10 -> 09.
// - CNT_AUTOREPEAT_EN, up held 20 EN ticks from 00 -> steps at ticks 1, 9, 11, 13, 15, 17, 19; out = 8'h07 at tick 20.

Source files
------------

// File: rtl/bcd_updown_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : bcd_updown_counter_n
// Purpose  : N-digit BCD up/down counter with a programmable MIN..MAX range,
//            preset load, and wrap or saturate behaviour at the limits.
//            The carry and borrow pulses allow counters to be cascaded
//            (seconds -> minutes -> hours).
// Ports    : clk    - system clock, all state changes on posedge
//            rst    - synchronous active-high reset
//            EN     - count enable / tick; only reset acts while low
//            up     - increment request
//            down   - decrement request
//            Ld     - load LOAD_VAL (wins over a simultaneous step)
//            wrap   - 1 = wrap at the limits, 0 = saturate at the limits
//            out    - BCD count, digit 0 in [3:0]
//            carry  - one-clk pulse after an up-wrap MAX -> MIN
//            borrow - one-clk pulse after a down-wrap MIN -> MAX
//            at_max - high while out == MAX_VAL
//            at_min - high while out == MIN_VAL
// Options  : define CNT_AUTOREPEAT_EN to make up/down edge-qualified with
//            auto-repeat (REP_DELAY ticks, then one step every REP_PERIOD).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_updown_counter_n #(
   parameter int DIGITS     = 2,
   parameter int MIN_VAL    = 0,
   parameter int MAX_VAL    = 59,
   parameter int LOAD_VAL   = 6,
   parameter int REP_DELAY  = 8,
   parameter int REP_PERIOD = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  EN,
   input  logic                  up,
   input  logic                  down,
   input  logic                  Ld,
   input  logic                  wrap,
   output logic [4*DIGITS-1:0]   out,
   output logic                  carry,
   output logic                  borrow,
   output logic                  at_max,
   output logic                  at_min
);

   localparam int W = 4 * DIGITS;

   // Decimal to packed BCD, used to build the constant limits.
   function automatic logic [W-1:0] f_to_bcd(input int value);
      logic [W-1:0] v_bcd;
      int           v_rem;
      v_bcd = '0;
      v_rem = value;
      for (int i = 0; i < DIGITS; i++) begin
         v_bcd[4*i +: 4] = 4'(v_rem % 10);
         v_rem           = v_rem / 10;
      end
      return v_bcd;
   endfunction

   function automatic longint f_pow10(input int n);
      longint v_p;
      v_p = 1;
      for (int i = 0; i < n; i++) begin
         v_p = v_p * 10;
      end
      return v_p;
   endfunction

   localparam logic [W-1:0] c_MIN_BCD  = f_to_bcd(MIN_VAL);
   localparam logic [W-1:0] c_MAX_BCD  = f_to_bcd(MAX_VAL);
   localparam logic [W-1:0] c_LOAD_BCD = f_to_bcd(LOAD_VAL);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   if (MIN_VAL > MAX_VAL) begin : g_chk_min_max
      $fatal(1, "bcd_updown_counter_n: MIN_VAL > MAX_VAL");
   end
   if ((LOAD_VAL < MIN_VAL) || (LOAD_VAL > MAX_VAL)) begin : g_chk_load
      $fatal(1, "bcd_updown_counter_n: LOAD_VAL outside MIN_VAL..MAX_VAL");
   end
   if ((MIN_VAL < 0) || (longint'(MAX_VAL) >= f_pow10(DIGITS))) begin : g_chk_digits
      $fatal(1, "bcd_updown_counter_n: range does not fit in DIGITS");
   end
   if ((REP_DELAY < 1) || (REP_PERIOD < 1)) begin : g_chk_rep
      $fatal(1, "bcd_updown_counter_n: REP_DELAY/REP_PERIOD must be >= 1");
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [W-1:0] r_out;
   logic         r_carry;
   logic         r_borrow;
   logic         r_at_max;
   logic         r_at_min;

   // ------------------------------------------------------------------------
   // Step request decode; simultaneous up and down cancel out.
   // ------------------------------------------------------------------------
   logic w_step_up;
   logic w_step_dn;
   logic w_fire_up;
   logic w_fire_dn;

   assign w_step_up = up & ~down;
   assign w_step_dn = down & ~up;

`ifdef CNT_AUTOREPEAT_EN
   localparam int c_REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int c_RW      = $clog2(c_REP_MAX + 1);
   localparam logic [c_RW-1:0] c_DELAY  = c_RW'(REP_DELAY);
   localparam logic [c_RW-1:0] c_PERIOD = c_RW'(REP_PERIOD);

   logic [1:0]      r_req_prev;   // request seen on the previous EN tick
   logic [c_RW-1:0] r_rep_cnt;    // EN ticks since the last step
   logic            r_repeating;  // initial delay done, now on period
   logic [1:0]      w_req;
   logic            w_new;
   logic            w_rep_hit;
   logic            w_fire;

   assign w_req     = {w_step_dn, w_step_up};
   // A request that differs from the last tick's request counts as a new
   // press, so switching directly from up to down also steps at once.
   assign w_new     = (w_req != 2'b00) && (w_req != r_req_prev);
   assign w_rep_hit = (w_req != 2'b00) && !w_new &&
                      (r_repeating ? (r_rep_cnt == c_PERIOD)
                                   : (r_rep_cnt == c_DELAY));
   assign w_fire    = w_new | w_rep_hit;
   assign w_fire_up = w_fire & w_step_up;
   assign w_fire_dn = w_fire & w_step_dn;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_prev  <= 2'b00;
         r_rep_cnt   <= '0;
         r_repeating <= 1'b0;
      end else if (EN) begin
         r_req_prev <= w_req;
         if (Ld || (w_req == 2'b00)) begin
            r_rep_cnt   <= '0;
            r_repeating <= 1'b0;
         end else if (w_fire) begin
            r_rep_cnt   <= c_RW'(1);
            r_repeating <= w_rep_hit;
         end else begin
            r_rep_cnt   <= r_rep_cnt + c_RW'(1);
         end
      end
   end
`else
   assign w_fire_up = w_step_up;
   assign w_fire_dn = w_step_dn;
`endif

   // ------------------------------------------------------------------------
   // Per-digit BCD increment / decrement with ripple between digits
   // ------------------------------------------------------------------------
   logic [W-1:0] w_inc;
   logic [W-1:0] w_dec;
   logic         w_inc_c;
   logic         w_dec_b;

   always_comb begin
      w_inc   = r_out;
      w_inc_c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_inc_c) begin
            if (r_out[4*i +: 4] == 4'd9) begin
               w_inc[4*i +: 4] = 4'd0;
            end else begin
               w_inc[4*i +: 4] = r_out[4*i +: 4] + 4'd1;
               w_inc_c         = 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_dec   = r_out;
      w_dec_b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_dec_b) begin
            if (r_out[4*i +: 4] == 4'd0) begin
               w_dec[4*i +: 4] = 4'd9;
            end else begin
               w_dec[4*i +: 4] = r_out[4*i +: 4] - 4'd1;
               w_dec_b         = 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state selection: !EN hold > Ld > step
   // ------------------------------------------------------------------------
   logic [W-1:0] w_nxt_out;
   logic         w_nxt_carry;
   logic         w_nxt_borrow;

   always_comb begin
      w_nxt_out    = r_out;
      w_nxt_carry  = 1'b0;
      w_nxt_borrow = 1'b0;
      if (EN) begin
         if (Ld) begin
            w_nxt_out = c_LOAD_BCD;
         end else if (w_fire_up) begin
            if (!r_at_max) begin
               w_nxt_out = w_inc;
            end else if (wrap) begin
               w_nxt_out   = c_MIN_BCD;
               w_nxt_carry = 1'b1;
            end
         end else if (w_fire_dn) begin
            if (!r_at_min) begin
               w_nxt_out = w_dec;
            end else if (wrap) begin
               w_nxt_out    = c_MAX_BCD;
               w_nxt_borrow = 1'b1;
            end
         end
      end
   end

   // Flags are derived from the next value so they always match out.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out    <= c_MIN_BCD;
         r_carry  <= 1'b0;
         r_borrow <= 1'b0;
         r_at_min <= 1'b1;
         r_at_max <= (c_MIN_BCD == c_MAX_BCD);
      end else begin
         r_out    <= w_nxt_out;
         r_carry  <= w_nxt_carry;
         r_borrow <= w_nxt_borrow;
         r_at_min <= (w_nxt_out == c_MIN_BCD);
         r_at_max <= (w_nxt_out == c_MAX_BCD);
      end
   end

   assign out    = r_out;
   assign carry  = r_carry;
   assign borrow = r_borrow;
   assign at_max = r_at_max;
   assign at_min = r_at_min;

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_updown_counter_n
// Purpose  : Self-checking bench for bcd_updown_counter_n with default
//            parameters (2 digits, 0..59, load 6). A vector table covers
//            load, enable, cancel and digit ripple; hand sequences cover
//            wrap/saturate, pulse width and reset. With CNT_AUTOREPEAT_EN
//            the auto-repeat timing is checked instead of level stepping.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_updown_counter_n;

   logic       clk;
   logic       rst;
   logic       tb_en;
   logic       tb_up;
   logic       tb_dn;
   logic       tb_ld;
   logic       tb_wrap;
   logic [7:0] tb_out;
   logic       tb_carry;
   logic       tb_borrow;
   logic       tb_at_max;
   logic       tb_at_min;

   int n_cmp;
   int n_err;

   bcd_updown_counter_n #(
      .DIGITS     (2),
      .MIN_VAL    (0),
      .MAX_VAL    (59),
      .LOAD_VAL   (6),
      .REP_DELAY  (8),
      .REP_PERIOD (2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .EN     (tb_en),
      .up     (tb_up),
      .down   (tb_dn),
      .Ld     (tb_ld),
      .wrap   (tb_wrap),
      .out    (tb_out),
      .carry  (tb_carry),
      .borrow (tb_borrow),
      .at_max (tb_at_max),
      .at_min (tb_at_min)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       up;
      logic       dn;
      logic       ld;
      logic       wr;
      logic [7:0] e_out;
      logic       e_c;
      logic       e_b;
      logic       e_mx;
      logic       e_mn;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic en, input logic up_i, input logic dn,
                      input logic ld, input logic wr, input logic [7:0] e_out,
                      input logic e_c, input logic e_b, input logic e_mx,
                      input logic e_mn);
      vec_t v;
      v.en = en; v.up = up_i; v.dn = dn; v.ld = ld; v.wr = wr;
      v.e_out = e_out; v.e_c = e_c; v.e_b = e_b; v.e_mx = e_mx; v.e_mn = e_mn;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] e_out,
                          input logic e_c, input logic e_b,
                          input logic e_mx, input logic e_mn);
      chk({tag, ".out"},    tb_out,           e_out);
      chk({tag, ".carry"},  {7'd0, tb_carry},  {7'd0, e_c});
      chk({tag, ".borrow"}, {7'd0, tb_borrow}, {7'd0, e_b});
      chk({tag, ".at_max"}, {7'd0, tb_at_max}, {7'd0, e_mx});
      chk({tag, ".at_min"}, {7'd0, tb_at_min}, {7'd0, e_mn});
   endtask

   // Drive inputs, take one clock edge, sample just after it.
   task automatic tick(input logic en, input logic up_i, input logic dn,
                       input logic ld, input logic wr);
      tb_en = en; tb_up = up_i; tb_dn = dn; tb_ld = ld; tb_wrap = wr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

`ifdef CNT_AUTOREPEAT_EN
   int step_ticks[7] = '{1, 9, 11, 13, 15, 17, 19};
`endif

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b0; tb_en = 1'b0; tb_up = 1'b0; tb_dn = 1'b0;
      tb_ld = 1'b0; tb_wrap = 1'b0;

      do_reset();
      chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

`ifndef CNT_AUTOREPEAT_EN
      //   en    up    dn    ld    wr    out    c     b     mx    mn
      add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0);

      foreach (vq[i]) begin
         tick(vq[i].en, vq[i].up, vq[i].dn, vq[i].ld, vq[i].wr);
         chk_all($sformatf("vec%0d", i), vq[i].e_out, vq[i].e_c, vq[i].e_b,
                 vq[i].e_mx, vq[i].e_mn);
      end

      // Limits: saturate then wrap downward, then wrap upward with carry.
      do_reset();
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_all("dn_sat", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk_all("dn_wrap", 8'h59, 1'b0, 1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_all("borrow_clr", 8'h59, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_all("up_sat", 8'h59, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk_all("dn_58", 8'h58, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk_all("up_59", 8'h59, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk_all("up_wrap", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk_all("carry_clr", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
      // Wrap followed by EN low: pulse must still drop after one clk.
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk_all("dn_wrap2", 8'h59, 1'b0, 1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk_all("pulse_en0", 8'h59, 1'b0, 1'b0, 1'b1, 1'b0);
      // Toggling wrap alone never changes the count.
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_all("wrap_toggle", 8'h59, 1'b0, 1'b0, 1'b1, 1'b0);
      // Reset while stepping.
      rst = 1'b1;
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      rst = 1'b0;
      chk_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
`else
      // Up held for 20 EN ticks: steps at ticks 1,9,11,13,15,17,19.
      for (int t = 1; t <= 20; t++) begin
         int nsteps;
         tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
         nsteps = 0;
         foreach (step_ticks[k]) if (step_ticks[k] <= t) nsteps++;
         chk($sformatf("rep_t%0d", t), tb_out, 8'(nsteps));
      end
      // Reset mid-repeat, then the still-held button counts as a new press.
      rst = 1'b1;
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      chk_all("rep_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk_all("rep_restart", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk_all("rep_held", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
      // Release then press down from 01 -> 00, again -> wrap 59.
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk_all("rep_dn", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk_all("rep_dn_wrap", 8'h59, 1'b0, 1'b1, 1'b1, 1'b0);
      // Ld wins over a fresh press.
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      chk_all("rep_ld", 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
